mp_cache_tag_ctrl: RTL and testbench

MP_CACHE_TAG_CTRL -- requirements
Module: mp_cache_tag_ctrl

---
 rtl/mp_cache_tag_ctrl.sv | 125 ++++++++++++
 tb/tb_mp_cache_tag_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mp_cache_tag_ctrl.sv
// Tag-array controller: sweeps the tag SRAM to zero after reset or on a
// flush request, then arbitrates single-cycle lookup reads and fill writes
// onto the one SRAM port (round-robin when both requesters contend).
module mp_cache_tag_ctrl #(
  parameter int TAG_WIDTH = 24,
  parameter int SET_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req,
  input  logic [SET_WIDTH-1:0] rd_set,
  output logic                 rd_ready,
  output logic                 rd_rvalid,
  output logic [TAG_WIDTH-1:0] rd_rdata,
  input  logic                 wr_req,
  input  logic [SET_WIDTH-1:0] wr_set,
  input  logic [TAG_WIDTH-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 flush_req,
  output logic                 busy,
  output logic                 sram_csb,
  output logic                 sram_web,
  output logic [SET_WIDTH-1:0] sram_addr,
  output logic [TAG_WIDTH-1:0] sram_din,
  input  logic [TAG_WIDTH-1:0] sram_dout
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [SET_WIDTH-1:0] CNT_LAST = {SET_WIDTH{1'b1}};

  logic [1:0]           state;
  logic [SET_WIDTH-1:0] cnt;
  logic                 rr_rd;    // 1: read wins next contention, 0: write wins
  logic                 rvld_q;   // read grant delayed to line up with sram_dout
  logic                 sweep;
  logic                 arb_en;
  logic                 rd_gnt;
  logic                 wr_gnt;

  assign sweep  = (state == ST_INIT) || (state == ST_FLUSH);
  // A flush request in IDLE pre-empts both requesters for that cycle.
  assign arb_en = (state == ST_IDLE) && !flush_req;

  // Grant selection: single requester wins outright, contention follows rr_rd.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (arb_en) begin
      if (rd_req && wr_req) begin
        rd_gnt = rr_rd;
        wr_gnt = !rr_rd;
      end else begin
        rd_gnt = rd_req;
        wr_gnt = wr_req;
      end
    end
  end

  assign rd_ready  = rd_gnt;
  assign wr_ready  = wr_gnt;
  assign busy      = sweep;
  assign rd_rvalid = rvld_q;
  assign rd_rdata  = rvld_q ? sram_dout : '0;

  // SRAM port mux; rst gates chip select so nothing is written while held in reset.
  always_comb begin
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    if (!rst) begin
      if (sweep) begin
        sram_csb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = cnt;
      end else if (wr_gnt) begin
        sram_csb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = wr_set;
        sram_din  = wr_data;
      end else if (rd_gnt) begin
        sram_csb  = 1'b0;
        sram_addr = rd_set;
      end
    end
  end

  // State and sweep counter; the counter wraps to 0 as the sweep ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT, ST_FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (flush_req) state <= ST_FLUSH;
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Round-robin pointer flips only when both requesters were arbitrated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          rr_rd <= 1'b0;
    else if (arb_en && rd_req && wr_req) rr_rd <= ~rr_rd;
  end

  // Read data valid one cycle after the read is presented to the SRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rvld_q <= 1'b0;
    else     rvld_q <= rd_gnt;
  end

endmodule

// File: tb/tb_mp_cache_tag_ctrl.sv
// Directed bench for mp_cache_tag_ctrl with a behavioural 1-cycle tag SRAM.
module tb_mp_cache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_set = '0;
  logic        rd_ready;
  logic        rd_rvalid;
  logic [23:0] rd_rdata;
  logic        wr_req = 1'b0;
  logic [3:0]  wr_set = '0;
  logic [23:0] wr_data = '0;
  logic        wr_ready;
  logic        flush_req = 1'b0;
  logic        busy;
  logic        sram_csb;
  logic        sram_web;
  logic [3:0]  sram_addr;
  logic [23:0] sram_din;
  logic [23:0] sram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] mem [16];

  mp_cache_tag_ctrl #(.TAG_WIDTH(24), .SET_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_set(rd_set), .rd_ready(rd_ready),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_set(wr_set), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush_req(flush_req), .busy(busy),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Tag SRAM: write or read on the clock edge, read data one cycle later.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout      <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check a full 16-cycle zero sweep starting in the current cycle.
  task automatic chk_sweep(input string tag, input bit pulse_flush);
    for (int i = 0; i < 16; i++) begin
      flush_req = pulse_flush && (i == 4);
      #1;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_sram"}, {sram_csb, sram_web, 26'd0, sram_addr}, {2'b00, 26'd0, i[3:0]});
      chk({tag, "_din"}, {8'd0, sram_din}, 32'd0);
      chk({tag, "_rdy"}, {30'd0, rd_ready, wr_ready}, 32'd0);
      tick();
    end
    flush_req = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held.
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_csb", {31'd0, sram_csb}, 32'd1);
    chk("rst_rvalid", {7'd0, rd_rvalid, rd_rdata}, 32'd0);
    chk("rst_rdy", {30'd0, rd_ready, wr_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk_sweep("init", 1'b0);
    chk("init_done", {31'd0, busy}, 32'd0);
    chk("idle_csb", {31'd0, sram_csb}, 32'd1);

    // Read set 5 after init -> 0.
    rd_req = 1'b1; rd_set = 4'd5; #1;
    chk("rd5_gnt", {rd_ready, wr_ready, sram_csb, sram_web, 24'd0, sram_addr}, {4'b1001, 24'd0, 4'd5});
    tick(); rd_req = 1'b0; #1;
    chk("rd5_data", {7'd0, rd_rvalid, rd_rdata}, {7'd0, 1'b1, 24'd0});
    tick();
    chk("rvalid_low", {7'd0, rd_rvalid, rd_rdata}, 32'd0);

    // Write set 3, read it back the next cycle.
    wr_req = 1'b1; wr_set = 4'd3; wr_data = 24'hABCDEF; #1;
    chk("wr3_gnt", {rd_ready, wr_ready, sram_csb, sram_web, 24'd0, sram_addr}, {4'b0100, 24'd0, 4'd3});
    chk("wr3_din", {8'd0, sram_din}, 32'h00ABCDEF);
    tick(); wr_req = 1'b0; rd_req = 1'b1; rd_set = 4'd3; #1;
    chk("rd3_gnt", {31'd0, rd_ready}, 32'd1);
    chk("rd3_novalid", {31'd0, rd_rvalid}, 32'd0);
    tick(); rd_req = 1'b0; #1;
    chk("rd3_data", {7'd0, rd_rvalid, rd_rdata}, {7'd0, 1'b1, 24'hABCDEF});
    tick();

    // Contention: write, read, write, read.
    rd_req = 1'b1; rd_set = 4'd3; wr_req = 1'b1; wr_set = 4'd7; wr_data = 24'h123456; #1;
    chk("rr1", {30'd0, wr_ready, rd_ready}, 32'd2);
    tick(); #1;
    chk("rr2", {30'd0, wr_ready, rd_ready}, 32'd1);
    tick(); #1;
    chk("rr3", {30'd0, wr_ready, rd_ready}, 32'd2);
    chk("rr3_data", {7'd0, rd_rvalid, rd_rdata}, {7'd0, 1'b1, 24'hABCDEF});
    tick(); #1;
    chk("rr4", {30'd0, wr_ready, rd_ready}, 32'd1);
    tick(); wr_req = 1'b0; rd_set = 4'd7; #1;
    chk("rr4_data", {7'd0, rd_rvalid, rd_rdata}, {7'd0, 1'b1, 24'hABCDEF});
    // Back-to-back reads: set 7 then set 3.
    chk("b2b1_gnt", {31'd0, rd_ready}, 32'd1);
    tick(); rd_set = 4'd3; #1;
    chk("b2b1_data", {7'd0, rd_rvalid, rd_rdata}, {7'd0, 1'b1, 24'h123456});
    tick(); rd_req = 1'b0; #1;
    chk("b2b2_data", {7'd0, rd_rvalid, rd_rdata}, {7'd0, 1'b1, 24'hABCDEF});
    tick();

    // Flush beats a simultaneous read; read held until granted after flush.
    flush_req = 1'b1; rd_req = 1'b1; rd_set = 4'd3; #1;
    chk("fl_nogrant", {29'd0, rd_ready, wr_ready, sram_csb}, 32'd1);
    tick();
    chk_sweep("flush", 1'b0);
    chk("fl_rd_gnt", {30'd0, busy, rd_ready}, 32'd1);
    tick(); rd_req = 1'b0; #1;
    chk("fl_rd_data", {7'd0, rd_rvalid, rd_rdata}, {7'd0, 1'b1, 24'd0});
    tick();

    // Reset in the middle of a flush sweep at count 7.
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("fl7_addr", {28'd0, sram_addr}, 32'd7);
    rst = 1'b1; #1;
    chk("mid_rst", {27'd0, busy, sram_csb, rd_ready, wr_ready, rd_rvalid}, 32'b11000);
    chk("mid_rst_rdata", {8'd0, rd_rdata}, 32'd0);
    tick();
    rst = 1'b0; #1;
    // Restarted INIT sweep with a flush pulse in the middle that must be ignored.
    chk_sweep("reinit", 1'b1);
    chk("reinit_done", {31'd0, busy}, 32'd0);
    tick();
    chk("reinit_stay", {30'd0, busy, sram_csb}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always reaches its summary.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
